// File: rtl/mem_ctl_pkg.sv
// mem_ctl_pkg: shared definitions for the mem_ctl arbiter slice.
//   arb_state_t : arbiter FSM state encoding (3 bits)
//   DEF_AW/DEF_DW : default address / data widths
package mem_ctl_pkg;

  localparam int unsigned DEF_AW = 8;
  localparam int unsigned DEF_DW = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    CMD_REL = 3'd2,
    RD_WAIT = 3'd3,
    RSP     = 3'd4,
    RSP_REL = 3'd5,
    DONE    = 3'd6
  } arb_state_t;

endpackage

// File: rtl/mem_ctl_rr_pick.sv
// mem_ctl_rr_pick: combinational round-robin selector.
//   req    : request vector, one bit per requester
//   rr_ptr : index the scan starts from (wraps at NUM_REQ)
//   found  : at least one request is set
//   index  : first set request at or after rr_ptr
module mem_ctl_rr_pick #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic                       found,
  output logic [$clog2(NUM_REQ)-1:0] index
);

  localparam int unsigned PW = $clog2(NUM_REQ);

  int unsigned      j;
  logic [PW-1:0]    cand;

  always_comb begin
    found = 1'b0;
    index = '0;
    j     = 0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      j = 32'(rr_ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      cand = j[PW-1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/mem_ctl_arbiter.sv
// mem_ctl_arbiter: round-robin sharing of one mem_ctl between NUM_REQ
// requesters. Runs both four-phase handshakes towards mem_ctl on behalf of
// the granted requester and holds the grant until they return to zero.
//   req_*          : requester command side (valid/ack four-phase)
//   rsp_*          : requester read response side (valid/ack four-phase)
//   mc_*           : mem_ctl upstream interface
//   grant/busy/err : current owner, FSM not idle, sticky timeout flag
// Optional macro ARB_TIMEOUT_EN: watchdog aborting stalled handshakes after
// TIMEOUT_CYCLES; without it err is tied low and waits are unbounded.
module mem_ctl_arbiter
  import mem_ctl_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned AW             = DEF_AW,
  parameter int unsigned DW             = DEF_DW,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_wen,
  input  logic [NUM_REQ*AW-1:0]      req_addr,
  input  logic [NUM_REQ*DW-1:0]      req_wdata,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic [NUM_REQ-1:0]         rsp_valid,
  input  logic [NUM_REQ-1:0]         rsp_ack,
  output logic [DW-1:0]              rsp_rdata,
  output logic                       mc_wen,
  output logic                       mc_din_valid,
  output logic [AW-1:0]              mc_addr,
  output logic [DW-1:0]              mc_wdata,
  input  logic                       mc_din_ack,
  input  logic                       mc_dout_valid,
  input  logic [DW-1:0]              mc_rdata,
  output logic                       mc_dout_ack,
  output logic [$clog2(NUM_REQ)-1:0] grant,
  output logic                       busy,
  output logic                       err
);

  localparam int unsigned GW = $clog2(NUM_REQ);

  arb_state_t         state_q, state_d;
  logic [GW-1:0]      rr_ptr_q, rr_ptr_d, grant_q, grant_d, pick_idx;
  logic               pick_found;
  logic               wen_q, wen_d, din_valid_q, din_valid_d, dout_ack_q, dout_ack_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [DW-1:0]      wdata_q, wdata_d, rdata_q, rdata_d;
  logic [NUM_REQ-1:0] req_ack_q, req_ack_d, rsp_valid_q, rsp_valid_d;
  logic               busy_q, tmo;

  mem_ctl_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr_q),
    .found  (pick_found),
    .index  (pick_idx)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q;

  // Fires on the cycle the count would reach TIMEOUT_CYCLES, so a stalled
  // state is abandoned after exactly TIMEOUT_CYCLES cycles.
  assign tmo = (state_q inside {CMD, RD_WAIT, RSP_REL}) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = '0;
    if (state_d == state_q && (state_q inside {CMD, RD_WAIT, RSP_REL})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (tmo) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    wen_d       = wen_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    din_valid_d = din_valid_q;
    dout_ack_d  = dout_ack_q;
    req_ack_d   = req_ack_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      IDLE: if (pick_found) begin
        grant_d     = pick_idx;
        wen_d       = req_wen[pick_idx];
        addr_d      = req_addr[pick_idx*AW +: AW];
        wdata_d     = req_wdata[pick_idx*DW +: DW];
        din_valid_d = 1'b1;
        state_d     = CMD;
      end
      CMD: if (mc_din_ack) begin
        din_valid_d         = 1'b0;
        req_ack_d[grant_q]  = 1'b1;
        state_d             = CMD_REL;
      end
      CMD_REL: if (!mc_din_ack && !req_valid[grant_q]) begin
        req_ack_d = '0;
        state_d   = wen_q ? DONE : RD_WAIT;
      end
      RD_WAIT: if (mc_dout_valid) begin
        rdata_d              = mc_rdata;
        rsp_valid_d[grant_q] = 1'b1;
        state_d              = RSP;
      end
      RSP: if (rsp_ack[grant_q]) begin
        dout_ack_d  = 1'b1;
        rsp_valid_d = '0;
        state_d     = RSP_REL;
      end
      RSP_REL: if (!mc_dout_valid && !rsp_ack[grant_q]) begin
        dout_ack_d = 1'b0;
        state_d    = DONE;
      end
      DONE: begin
        rr_ptr_d = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (tmo) begin
      din_valid_d = 1'b0;
      dout_ack_d  = 1'b0;
      wen_d       = 1'b0;
      addr_d      = '0;
      wdata_d     = '0;
      rdata_d     = '0;
      req_ack_d   = '0;
      rsp_valid_d = '0;
      state_d     = DONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      wen_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      din_valid_q <= 1'b0;
      dout_ack_q  <= 1'b0;
      req_ack_q   <= '0;
      rsp_valid_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      wen_q       <= wen_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      din_valid_q <= din_valid_d;
      dout_ack_q  <= dout_ack_d;
      req_ack_q   <= req_ack_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= (state_d != IDLE);
    end
  end

  assign req_ack      = req_ack_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rdata_q;
  assign mc_wen       = wen_q;
  assign mc_din_valid = din_valid_q;
  assign mc_addr      = addr_q;
  assign mc_wdata     = wdata_q;
  assign mc_dout_ack  = dout_ack_q;
  assign grant        = grant_q;
  assign busy         = busy_q;

endmodule

// File: doc/mem_ctl_arbiter.md
Name: mem_ctl_arbiter

Overview:
Shares one mem_ctl instance between NUM_REQ requesters using round-robin arbitration. It drives the controller's upstream four-phase handshakes (wen/din_valid/din_ack and dout_valid/dout_ack) on behalf of one granted requester at a time. It routes read data back to the granted requester and keeps the grant until that transaction's handshakes have fully returned to zero. It sits between client blocks and mem_ctl.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
AW, 8, address width
DW, 8, data width
TIMEOUT_CYCLES, 255, watchdog limit (used only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester command valid (four-phase)
req_wen  in  NUM_REQ  1=write, 0=read
req_addr  in  NUM_REQ*AW  per-requester address
req_wdata  in  NUM_REQ*DW  per-requester write data
req_ack  out  NUM_REQ  command accepted (four-phase)
rsp_valid  out  NUM_REQ  read data valid (four-phase)
rsp_ack  in  NUM_REQ  read data consumed
rsp_rdata  out  DW  read data, shared bus, meaningful only with rsp_valid
mc_wen, mc_din_valid  out  1  to mem_ctl
mc_addr  out  AW  to mem_ctl
mc_wdata  out  DW  to mem_ctl
mc_din_ack, mc_dout_valid  in  1  from mem_ctl
mc_rdata  in  DW  from mem_ctl
mc_dout_ack  out  1  to mem_ctl
grant  out  clog2(NUM_REQ)  index of current owner
busy  out  1  arbiter not in IDLE
err  out  1  sticky timeout flag

Behaviour:
- Reset values: all outputs 0; rr_ptr=0; state=IDLE. All outputs are registered.
- IDLE: if any req_valid is set, pick the first set index scanning from rr_ptr upward with wrap. Latch grant, wen, addr and wdata. Go to CMD. Entering CMD takes 1 cycle.
- CMD: mc_din_valid=1, mc_wen/mc_addr/mc_wdata held from the latch. Wait for mc_din_ack=1. Then mc_din_valid<=0 and req_ack[grant]<=1, and go to CMD_REL.
- CMD_REL: wait until mc_din_ack=0 and req_valid[grant]=0. Then req_ack[grant]<=0. Next state is DONE for a write, RD_WAIT for a read.
- RD_WAIT: wait for mc_dout_valid=1. Capture mc_rdata into rsp_rdata and set rsp_valid[grant]<=1. Go to RSP.
- RSP: wait for rsp_ack[grant]=1. Then mc_dout_ack<=1 and rsp_valid[grant]<=0. Go to RSP_REL.
- RSP_REL: wait until mc_dout_valid=0 and rsp_ack[grant]=0. Then mc_dout_ack<=0. Go to DONE.
- DONE: rr_ptr<=grant+1, wrapping at NUM_REQ. Go to IDLE. There is at least one idle cycle between grants.
- Latched command fields are frozen for the whole transaction. Requester input changes after the grant are ignored.
- Simultaneous requests: round-robin order. With all requesters active, each gets a grant once every NUM_REQ transactions.
- A requester dropping req_valid before req_ack is a protocol violation. The arbiter keeps waiting in CMD; it does not abort.
- Only the granted requester's req_ack/rsp_valid bit is ever nonzero.
- Asynchronous reset mid-transaction returns everything to the reset values immediately. The downstream mem_ctl must be reset together with the arbiter.

Optional Feature:
ARB_TIMEOUT_EN
- With the macro: an 8+ bit counter clears on every state change and increments while in CMD, RD_WAIT or RSP_REL. When it reaches TIMEOUT_CYCLES:
  - err<=1 (sticky until reset);
  - all mc_* and req/rsp outputs are driven to 0;
  - the state goes to DONE.
- Without the macro: no counter, err is tied to 0, and the arbiter waits indefinitely.

Decomposition:
- Package mem_ctl_pkg holds:
  - the state encoding constants (IDLE, CMD, CMD_REL, RD_WAIT, RSP, RSP_REL, DONE), 3 bits;
  - default AW/DW.
- One sub-module, mem_ctl_rr_pick: combinational round-robin selector with inputs req vector and rr_ptr, and outputs found and index.
- The FSM, latches and counter stay in mem_ctl_arbiter.

Test Plan:
- Write from req0, addr=0x12, wdata=0xA5:
  - mc_din_valid rises 1 cycle after req_valid with mc_addr=0x12, mc_wdata=0xA5, mc_wen=1;
  - req_ack[0] rises after mc_din_ack;
  - no rsp_valid.
- Read by req1 at addr=0x34 with a mem_ctl model returning 0x5C:
  - rsp_valid[1]=1 and rsp_rdata=0x5C;
  - mc_dout_ack asserts only after rsp_ack[1];
  - all signals return to 0; busy=0.
- req0 and req1 both asserted continuously for 4 transactions -> grant sequence 0,1,0,1.
- req1 delays rsp_ack by 20 cycles -> rsp_valid[1] held for 20 cycles; mc_dout_ack stays 0 until rsp_ack.
- rst_n pulsed low during RD_WAIT -> all outputs 0 in the same cycle; next request is granted to req0.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16 and mem_ctl never asserting mc_din_ack -> err=1 after 16 CMD cycles, mc_din_valid=0, back in IDLE; err stays 1 through later transactions.
